// File: rtl/ram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ram_arbiter                                                  |
// | Description : Two-requester round-robin arbiter and sequencer in front of  |
// |               a 64 x 8 single-port RAM with registered read output.        |
// |               One read or write in flight at a time; completion pulse and  |
// |               per-requester held read data.                                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ram_arbiter #(
  parameter int AW = 6,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          wr0,
  input  logic          wr1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          done0,
  output logic          done1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          busy,
  output logic          ram_we,
  output logic [DW-1:0] ram_data,
  output logic [AW-1:0] ram_read_addr,
  output logic [AW-1:0] ram_write_addr,
  input  logic [DW-1:0] ram_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2
  } state_t;

  state_t r_state;
  logic   r_last;   // requester granted most recently
  logic   r_owner;  // requester owning the operation in flight
  logic   r_op_wr;  // operation in flight is a write

  // Winner selection: on contention pick the requester that was not granted last
  logic          w_any;
  logic          w_pick1;
  logic          w_sel_wr;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_wdata;

  assign w_any       = req0 | req1;
  assign w_pick1     = (req0 & req1) ? ~r_last : req1;
  assign w_sel_wr    = w_pick1 ? wr1    : wr0;
  assign w_sel_addr  = w_pick1 ? addr1  : addr0;
  assign w_sel_wdata = w_pick1 ? wdata1 : wdata0;

  // Sequencer FSM: grant in IDLE, drive the RAM in ACCESS, capture read data in WAIT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_last         <= 1'b1;
      r_owner        <= 1'b0;
      r_op_wr        <= 1'b0;
      gnt0           <= 1'b0;
      gnt1           <= 1'b0;
      done0          <= 1'b0;
      done1          <= 1'b0;
      rdata0         <= '0;
      rdata1         <= '0;
      busy           <= 1'b0;
      ram_we         <= 1'b0;
      ram_data       <= '0;
      ram_read_addr  <= '0;
      ram_write_addr <= '0;
    end else begin
      // Pulses default low; they are raised for exactly one cycle below
      gnt0   <= 1'b0;
      gnt1   <= 1'b0;
      done0  <= 1'b0;
      done1  <= 1'b0;
      ram_we <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_owner <= w_pick1;
            r_last  <= w_pick1;
            r_op_wr <= w_sel_wr;
            gnt0    <= ~w_pick1;
            gnt1    <= w_pick1;
            busy    <= 1'b1;
            r_state <= ACCESS;
            // RAM pins are loaded here so they are stable for the whole ACCESS cycle
            if (w_sel_wr) begin
              ram_we         <= 1'b1;
              ram_write_addr <= w_sel_addr;
              ram_data       <= w_sel_wdata;
            end else begin
              ram_read_addr  <= w_sel_addr;
            end
          end
        end
        ACCESS: begin
          if (r_op_wr) begin
            // Write lands at this edge; report completion in the next IDLE cycle
            done0   <= ~r_owner;
            done1   <= r_owner;
            busy    <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_state <= WAIT;
          end
        end
        WAIT: begin
          // ram_out now holds the addressed byte
          if (r_owner) begin
            rdata1 <= ram_out;
          end else begin
            rdata0 <= ram_out;
          end
          done0   <= ~r_owner;
          done1   <= r_owner;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester round-robin arbiter and sequencer for the 64 x 8 single-port RAM (registered read, write-has-priority port). It accepts one read or write at a time from either requester, drives the RAM control, address and data pins, and returns read data with a completion pulse. It sits directly in front of the RAM instance; requesters never touch the RAM pins.

## Interface
- AW, 6, address width (RAM depth 2**AW)
- DW, 8, data width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req0, req1  in  1  operation pending from requester 0 / 1
- wr0, wr1  in  1  1 = write, 0 = read; sampled with req
- addr0, addr1  in  AW  target address
- wdata0, wdata1  in  DW  write data
- gnt0, gnt1  out  1  one-cycle pulse: request accepted, fields latched
- done0, done1  out  1  one-cycle pulse: operation complete
- rdata0, rdata1  out  DW  read result, valid from the done cycle and held until that requester's next read completes
- busy  out  1  high whenever the FSM is not in IDLE
- ram_we  out  1  RAM write enable
- ram_data  out  DW  RAM write data
- ram_read_addr, ram_write_addr  out  AW  RAM addresses
- ram_out  in  DW  RAM registered read output

## Operation
- All outputs are registered. Reset value of every output is 0. Reset also sets state = IDLE and last = 1, so requester 0 wins the first contested grant.
- States: IDLE, ACCESS, WAIT.
- IDLE: a request is sampled only here. One request pending -> grant it. Both pending -> grant the requester != last. Neither pending -> stay. On grant: latch wr/addr/wdata into op registers, set owner, update last = owner, pulse gnt<owner>, go to ACCESS.
- ACCESS: write -> ram_we = 1, ram_write_addr = addr, ram_data = wdata, next state IDLE. Read -> ram_we = 0, ram_read_addr = addr, next state WAIT.
- WAIT: ram_out holds the addressed byte. At the end of the cycle, capture it into rdata<owner> and go to IDLE.
- done<owner> pulses in the first IDLE cycle after the operation completes.
- ram_we is 1 only during ACCESS of a write. Addresses and ram_data hold their last driven values otherwise.
- In IDLE the RAM free-runs reads of the held ram_read_addr. This is harmless because ram_out is captured only in WAIT.
- A requester may change its fields or drop req any time after seeing gnt. If req is still high at the next IDLE sample, it is a new request.
- The non-owner's rdata and done are untouched by an operation.

## Timing
- Edge E0: IDLE samples req. gnt high and ACCESS active during cycle C1.
- Write: the RAM write occurs at edge E1. done is high in C2, which is also an IDLE cycle. The next grant can occur at E2. Throughput is one write per 2 cycles.
- Read: ram_out is valid in C2 (WAIT). rdata is updated and done is high in C3 (IDLE). Throughput is one read per 3 cycles.
- Because grants alternate and each requester is granted at most once per operation, neither requester starves while both hold req continuously.
- Asserting rst at any point forces IDLE and all outputs to 0 immediately.
  - ram_we drops asynchronously, so a write in flight is aborted and the RAM content at that address is undefined.
  - No done is issued for the aborted operation.
  - rdata0 and rdata1 clear to 0.
  - After rst deasserts, the first grant follows the normal IDLE rules with last = 1.

## Test plan
- Reset, then req0 write addr 5 data 0xA5 -> gnt0 in C1, ram_we = 1 with ram_write_addr = 5 in C1, done0 in C2. Then req0 read addr 5 -> done0 in the 3rd cycle after the grant edge, rdata0 = 0xA5.
- req0 and req1 asserted together in the first cycle after reset, writing 0x11 and 0x22 to addrs 1 and 2 -> gnt0 first, then gnt1. Hold both req high with reads of addrs 2 and 1 -> grants alternate 0, 1, 0, ...; rdata0 = 0x22, rdata1 = 0x11.
- Boundary addresses: write 0xFF to addr 63 and 0x00 to addr 0, then read both -> exact values returned, no aliasing.
- req1 alone reads addr 63 while rdata0 holds 0x5A -> rdata1 = 0xFF, rdata0 stays 0x5A, done0 stays low.
- rst pulsed during ACCESS of a write -> ram_we = 0 in the same cycle, all outputs 0, no done. The next request is granted normally two cycles after rst deasserts.
- req held continuously high by requester 0 alone -> back-to-back writes every 2 cycles, reads every 3 cycles; busy is low only in IDLE cycles.
